lab1_imul_prod_accum: RTL and testbench
=======================================

// Module: lab1_imul_prod_accum
//
// PURPOSE
//   Downstream consumer of the fixed-latency integer multiplier. Takes a
//   length from a config stream, then accepts exactly that many 32-bit
//   products on its input stream and sums them (dot-product reduction).
//   Emits one 32-bit sum on the output stream, then returns to idle for
//   the next config. All three interfaces use val/rdy handshakes.
//
// PARAMETERS
//   p_len_nbits   8    width of the config length; max products per sum = 2**p_len_nbits-1
//
// PORTS
//   clk          in   1            clock; all state updates on posedge
//   reset        in   1            synchronous, active-high reset
//   cfg_val      in   1            config valid
//   cfg_rdy      out  1            config ready
//   cfg_msg      in   p_len_nbits  number of products N to accumulate
//   istream_val  in   1            product valid (from multiplier ostream)
//   istream_rdy  out  1            product ready
//   istream_msg  in   32           product
//   ostream_val  out  1            sum valid
//   ostream_rdy  in   1            sum ready
//   ostream_msg  out  32           sum, mod 2**32
//
// BEHAVIOUR
//   - Reset is synchronous and active-high. After the first reset edge:
//     state=IDLE, sum=0, remaining=0.
//     Outputs after reset: cfg_rdy=1, istream_rdy=0, ostream_val=0, ostream_msg=0.
//   - FSM states and transitions:
//     IDLE: cfg_rdy=1. On cfg_val, load remaining=cfg_msg and clear sum=0.
//           If cfg_msg==0, go to DONE; otherwise go to ACCUM.
//     ACCUM: istream_rdy=1. On each istream_val, sum<=sum+istream_msg and
//           remaining<=remaining-1. Go to DONE on the beat where remaining==1.
//     DONE: ostream_val=1. On ostream_rdy, go to IDLE.
//   - Handshake signals are decoded from state only. They never depend
//     combinationally on val/rdy inputs.
//   - A transfer occurs only on cycles where val and rdy are both 1.
//     Input val signals are ignored in states where the matching rdy is 0.
//   - cfg_rdy=0 in DONE, so no config is accepted on the same cycle as a
//     sum is sent. Minimum gap is one IDLE cycle between jobs.
//   - Latency: when the last product is accepted at cycle t, ostream_val=1
//     from cycle t+1 and holds until the handshake.
//   - ostream_msg = sum register, driven in every state.
//     While ostream_val=1 with ostream_rdy=0 it holds steady.
//   - Addition is 32-bit unsigned and wraps; carry-out is discarded.
//     Signed products accumulate correctly under two's complement.
//   - Products may arrive with gaps (istream_val low): state, sum and
//     remaining all hold.
//   - Reset asserted in any state aborts the job on the next edge and
//     returns to the reset values; any partial sum is discarded.
//   - remaining never underflows; N=2**p_len_nbits-1 must work.
//
// STRUCTURE
//   - Package lab1_imul_accum_pkg holds:
//     - enum state_t {IDLE, ACCUM, DONE}, 2-bit encoding
//     - localparam c_sum_nbits = 32
//   - Split into datapath and control. Sub-module lab1_imul_prod_accum_ctrl
//     holds the FSM and the remaining-count; it outputs the load, clear and
//     accumulate enables plus all rdy/val signals.
//   - The datapath (sum register and adder) lives in the top-level module.
//   - Reuse vc_EnReg, vc_SimpleAdder and vc_Mux2 from vc/.
//
// TESTING
//   1. N=3, products 2, 3, 4 back-to-back, ostream_rdy=1 -> ostream_msg=9,
//      ostream_val high exactly 1 cycle after the 3rd accept.
//   2. N=0 -> DONE with ostream_msg=0 without accepting any product;
//      istream_rdy stays 0 throughout.
//   3. N=2, products 0xFFFFFFFF and 0x00000002 -> 0x00000001 (wrap).
//      N=2, products -5 and 3 -> 0xFFFFFFFE.
//   4. Random val gaps on istream plus ostream_rdy held low 5 cycles:
//      sum stable while stalled, no extra product consumed, cfg_rdy=0 in DONE.
//   5. Reset asserted mid-ACCUM after 2 of 4 products -> next edge shows
//      cfg_rdy=1, ostream_msg=0. A new N=1 job with product 7 then yields 7.
//   6. Chained with lab1_imul_IntMulBase: N=4, operand pairs (1,2) (3,4)
//      (5,6) (7,8) -> 100. Random delays on source and sink.

Source files
------------

// File: rtl/lab1_imul_prod_accum_pkg.sv
// rtl/lab1_imul_prod_accum_pkg.sv - shared types and constants for the product accumulator
package lab1_imul_accum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int c_sum_nbits = 32;

endpackage

// File: rtl/lab1_imul_prod_accum_if.sv
// rtl/lab1_imul_prod_accum_if.sv - val/rdy message stream interface
interface lab1_imul_prod_accum_if #(
    parameter int p_nbits = 32
);
    logic               val;
    logic               rdy;
    logic [p_nbits-1:0] msg;

    modport master (output val, output msg, input rdy);
    modport slave  (input val, input msg, output rdy);
endinterface

// File: rtl/lab1_imul_prod_accum_ctrl.sv
// rtl/lab1_imul_prod_accum_ctrl.sv - job FSM and remaining-product counter
module lab1_imul_prod_accum_ctrl
    import lab1_imul_accum_pkg::*;
#(
    parameter int p_len_nbits = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_val,
    input  logic [p_len_nbits-1:0] cfg_msg,
    input  logic                   istream_val,
    input  logic                   ostream_rdy,
    output logic                   cfg_rdy,
    output logic                   istream_rdy,
    output logic                   ostream_val,
    output logic                   sum_clear,
    output logic                   sum_accum
);
    state_t                 state;
    state_t                 state_next;
    logic [p_len_nbits-1:0] remaining;
    logic                   cfg_go;
    logic                   prod_go;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // rdy/val come from state alone; only the enables look at the input valids
    always_comb begin
        state_next  = state;
        cfg_rdy     = 1'b0;
        istream_rdy = 1'b0;
        ostream_val = 1'b0;
        cfg_go      = 1'b0;
        prod_go     = 1'b0;
        case (state)
            IDLE: begin
                cfg_rdy = 1'b1;
                cfg_go  = cfg_val;
                if (cfg_val)
                    state_next = (cfg_msg == '0) ? DONE : ACCUM;
            end
            ACCUM: begin
                istream_rdy = 1'b1;
                prod_go     = istream_val;
                if (istream_val && remaining == p_len_nbits'(1))
                    state_next = DONE;
            end
            DONE: begin
                ostream_val = 1'b1;
                if (ostream_rdy)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign sum_clear = cfg_go;
    assign sum_accum = prod_go;

    always_ff @(posedge clk) begin
        if (reset)        remaining <= '0;
        else if (cfg_go)  remaining <= cfg_msg;
        else if (prod_go) remaining <= remaining - p_len_nbits'(1);
    end
endmodule

// File: rtl/vc_EnReg.sv
// rtl/vc_EnReg.sv - enabled register with synchronous active-high reset to zero
module vc_EnReg #(
    parameter int p_nbits = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [p_nbits-1:0] d,
    output logic [p_nbits-1:0] q
);
    always_ff @(posedge clk) begin
        if (reset)   q <= '0;
        else if (en) q <= d;
    end
endmodule

// File: rtl/vc_Mux2.sv
// rtl/vc_Mux2.sv - two-input multiplexer
module vc_Mux2 #(
    parameter int p_nbits = 1
) (
    input  logic [p_nbits-1:0] in0,
    input  logic [p_nbits-1:0] in1,
    input  logic               sel,
    output logic [p_nbits-1:0] out
);
    assign out = sel ? in1 : in0;
endmodule

// File: rtl/vc_SimpleAdder.sv
// rtl/vc_SimpleAdder.sv - wrapping adder, carry-out discarded
module vc_SimpleAdder #(
    parameter int p_nbits = 1
) (
    input  logic [p_nbits-1:0] in0,
    input  logic [p_nbits-1:0] in1,
    output logic [p_nbits-1:0] out
);
    assign out = in0 + in1;
endmodule

// File: rtl/lab1_imul_prod_accum.sv
// rtl/lab1_imul_prod_accum.sv - sums N products from a stream and emits the 32-bit total
module lab1_imul_prod_accum
    import lab1_imul_accum_pkg::*;
#(
    parameter int p_len_nbits = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    lab1_imul_prod_accum_if.slave   cfg,
    lab1_imul_prod_accum_if.slave   istream,
    lab1_imul_prod_accum_if.master  ostream
);
    logic                   sum_clear;
    logic                   sum_accum;
    logic [c_sum_nbits-1:0] sum;
    logic [c_sum_nbits-1:0] add_out;
    logic [c_sum_nbits-1:0] sum_d;
    logic [c_sum_nbits-1:0] zero;

    assign zero = '0;

    lab1_imul_prod_accum_ctrl #(.p_len_nbits(p_len_nbits)) ctrl (
        .clk         (clk),
        .reset       (reset),
        .cfg_val     (cfg.val),
        .cfg_msg     (cfg.msg),
        .istream_val (istream.val),
        .ostream_rdy (ostream.rdy),
        .cfg_rdy     (cfg.rdy),
        .istream_rdy (istream.rdy),
        .ostream_val (ostream.val),
        .sum_clear   (sum_clear),
        .sum_accum   (sum_accum)
    );

    vc_SimpleAdder #(.p_nbits(c_sum_nbits)) adder (
        .in0 (sum),
        .in1 (istream.msg),
        .out (add_out)
    );

    // a new config zeroes the sum instead of adding
    vc_Mux2 #(.p_nbits(c_sum_nbits)) sum_mux (
        .in0 (add_out),
        .in1 (zero),
        .sel (sum_clear),
        .out (sum_d)
    );

    vc_EnReg #(.p_nbits(c_sum_nbits)) sum_reg (
        .clk   (clk),
        .reset (reset),
        .en    (sum_clear | sum_accum),
        .d     (sum_d),
        .q     (sum)
    );

    assign ostream.msg = sum;
endmodule

// File: tb/tb_lab1_imul_prod_accum.sv
// tb/tb_lab1_imul_prod_accum.sv - scoreboard testbench for the product accumulator
module tb_lab1_imul_prod_accum;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   passed = 0;
    int   total  = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    lab1_imul_prod_accum_if #(.p_nbits(8))  cfg_if ();
    lab1_imul_prod_accum_if #(.p_nbits(32)) in_if ();
    lab1_imul_prod_accum_if #(.p_nbits(32)) out_if ();

    lab1_imul_prod_accum #(.p_len_nbits(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .cfg     (cfg_if.slave),
        .istream (in_if.slave),
        .ostream (out_if.master)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send_cfg(input logic [7:0] n);
        int k = 0;
        cfg_if.val = 1'b1;
        cfg_if.msg = n;
        while (!cfg_if.rdy && k < 1000) begin
            @(posedge clk); @(negedge clk); k++;
        end
        if (k >= 1000) begin
            total++;
            $display("FAIL cfg_timeout: cfg_rdy never seen, required 1");
        end else begin
            @(posedge clk); @(negedge clk);
        end
        cfg_if.val = 1'b0;
    endtask

    task automatic send_prod(input logic [31:0] p, input int gap);
        int k = 0;
        in_if.val = 1'b0;
        repeat (gap) @(negedge clk);
        in_if.val = 1'b1;
        in_if.msg = p;
        while (!in_if.rdy && k < 1000) begin
            @(posedge clk); @(negedge clk); k++;
        end
        if (k >= 1000) begin
            total++;
            $display("FAIL prod_timeout: istream_rdy never seen, required 1");
        end else begin
            @(posedge clk); @(negedge clk);
        end
        in_if.val = 1'b0;
    endtask

    task automatic recv(input int delay, output logic [31:0] got, output bit ok);
        ok = 1'b0;
        got = '0;
        repeat (delay) @(negedge clk);
        out_if.rdy = 1'b1;
        for (int i = 0; i < 1000 && !ok; i++) begin
            if (out_if.val === 1'b1) begin
                got = out_if.msg;
                ok = 1'b1;
            end
            @(posedge clk); @(negedge clk);
        end
        out_if.rdy = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (cfg_if.rdy !== 1'b1) $display("FAIL reset_cfg_rdy: got %b want 1", cfg_if.rdy); else passed++;
        total++; if (in_if.rdy !== 1'b0) $display("FAIL reset_istream_rdy: got %b want 0", in_if.rdy); else passed++;
        total++; if (out_if.val !== 1'b0) $display("FAIL reset_ostream_val: got %b want 0", out_if.val); else passed++;
        total++; if (out_if.msg !== 32'd0) $display("FAIL reset_ostream_msg: got %h want 0", out_if.msg); else passed++;
    endtask

    task automatic test_basic();
        logic [31:0] got, want;
        bit ok;
        exp_q.push_back(32'd9);
        send_cfg(8'd3);
        send_prod(32'd2, 0);
        send_prod(32'd3, 0);
        total++; if (out_if.val !== 1'b0) $display("FAIL basic_early_val: got %b want 0", out_if.val); else passed++;
        send_prod(32'd4, 0);
        total++; if (out_if.val !== 1'b1) $display("FAIL basic_latency: got %b want 1", out_if.val); else passed++;
        total++; if (in_if.rdy !== 1'b0) $display("FAIL basic_done_istream_rdy: got %b want 0", in_if.rdy); else passed++;
        recv(0, got, ok);
        want = exp_q.pop_front();
        total++; if (!ok || got !== want) $display("FAIL basic_sum: got %h ok %b want %h", got, ok, want); else passed++;
        total++; if (cfg_if.rdy !== 1'b1) $display("FAIL basic_back_idle: got %b want 1", cfg_if.rdy); else passed++;
    endtask

    task automatic test_zero_len();
        logic [31:0] got, want;
        bit ok;
        bit saw_rdy = 1'b0;
        exp_q.push_back(32'd0);
        in_if.val = 1'b1;
        in_if.msg = 32'd55;
        if (in_if.rdy !== 1'b0) saw_rdy = 1'b1;
        cfg_if.val = 1'b1;
        cfg_if.msg = 8'd0;
        @(posedge clk); @(negedge clk);
        cfg_if.val = 1'b0;
        if (in_if.rdy !== 1'b0) saw_rdy = 1'b1;
        total++; if (out_if.val !== 1'b1) $display("FAIL zero_done_val: got %b want 1", out_if.val); else passed++;
        recv(2, got, ok);
        if (in_if.rdy !== 1'b0) saw_rdy = 1'b1;
        in_if.val = 1'b0;
        want = exp_q.pop_front();
        total++; if (!ok || got !== want) $display("FAIL zero_sum: got %h ok %b want %h", got, ok, want); else passed++;
        total++; if (saw_rdy) $display("FAIL zero_istream_rdy: got 1 want 0"); else passed++;
    endtask

    task automatic test_wrap();
        logic [31:0] got, want;
        bit ok;
        exp_q.push_back(32'h0000_0001);
        send_cfg(8'd2);
        send_prod(32'hFFFF_FFFF, 0);
        send_prod(32'h0000_0002, 0);
        recv(0, got, ok);
        want = exp_q.pop_front();
        total++; if (!ok || got !== want) $display("FAIL wrap_unsigned: got %h ok %b want %h", got, ok, want); else passed++;
        exp_q.push_back(32'hFFFF_FFFE);
        @(negedge clk);
        send_cfg(8'd2);
        send_prod(-32'sd5, 0);
        send_prod(32'd3, 0);
        recv(0, got, ok);
        want = exp_q.pop_front();
        total++; if (!ok || got !== want) $display("FAIL wrap_signed: got %h ok %b want %h", got, ok, want); else passed++;
    endtask

    task automatic test_stall();
        logic [31:0] got, want, acc, p;
        bit ok;
        bit bad_hold = 1'b0;
        acc = '0;
        send_cfg(8'd5);
        for (int i = 0; i < 5; i++) begin
            p = $urandom;
            acc = acc + p;
            send_prod(p, $urandom_range(0, 3));
        end
        exp_q.push_back(acc);
        cfg_if.val = 1'b1;
        cfg_if.msg = 8'd3;
        in_if.val = 1'b1;
        in_if.msg = 32'h1234_5678;
        for (int c = 0; c < 5; c++) begin
            if (out_if.val !== 1'b1 || out_if.msg !== acc || cfg_if.rdy !== 1'b0 || in_if.rdy !== 1'b0)
                bad_hold = 1'b1;
            @(posedge clk); @(negedge clk);
        end
        total++; if (bad_hold) $display("FAIL stall_hold: val %b msg %h cfg_rdy %b want val 1 msg %h cfg_rdy 0", out_if.val, out_if.msg, cfg_if.rdy, acc); else passed++;
        cfg_if.val = 1'b0;
        in_if.val = 1'b0;
        recv(0, got, ok);
        want = exp_q.pop_front();
        total++; if (!ok || got !== want) $display("FAIL stall_sum: got %h ok %b want %h", got, ok, want); else passed++;
        total++; if (out_if.val !== 1'b0 || cfg_if.rdy !== 1'b1) $display("FAIL stall_idle: val %b cfg_rdy %b want 0 1", out_if.val, cfg_if.rdy); else passed++;
    endtask

    task automatic test_reset_abort();
        logic [31:0] got, want;
        bit ok;
        send_cfg(8'd4);
        send_prod(32'd10, 0);
        send_prod(32'd20, 0);
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        total++; if (cfg_if.rdy !== 1'b1) $display("FAIL abort_cfg_rdy: got %b want 1", cfg_if.rdy); else passed++;
        total++; if (out_if.msg !== 32'd0) $display("FAIL abort_msg: got %h want 0", out_if.msg); else passed++;
        total++; if (in_if.rdy !== 1'b0) $display("FAIL abort_istream_rdy: got %b want 0", in_if.rdy); else passed++;
        reset = 1'b0;
        exp_q.push_back(32'd7);
        send_cfg(8'd1);
        send_prod(32'd7, 0);
        recv(0, got, ok);
        want = exp_q.pop_front();
        total++; if (!ok || got !== want) $display("FAIL abort_new_job: got %h ok %b want %h", got, ok, want); else passed++;
    endtask

    task automatic test_max_len();
        logic [31:0] got, want, acc;
        bit ok;
        acc = '0;
        send_cfg(8'd255);
        for (int i = 1; i <= 255; i++) begin
            acc = acc + 32'(i);
            send_prod(32'(i), 0);
        end
        exp_q.push_back(acc);
        total++; if (in_if.rdy !== 1'b0 || out_if.val !== 1'b1) $display("FAIL max_done: istream_rdy %b val %b want 0 1", in_if.rdy, out_if.val); else passed++;
        recv(0, got, ok);
        want = exp_q.pop_front();
        total++; if (!ok || got !== want) $display("FAIL max_sum: got %h ok %b want %h", got, ok, want); else passed++;
    endtask

    task automatic test_mul_chain();
        logic [31:0] got, want, acc;
        bit ok;
        int a[4] = '{1, 3, 5, 7};
        int b[4] = '{2, 4, 6, 8};
        acc = '0;
        send_cfg(8'd4);
        for (int i = 0; i < 4; i++) begin
            acc = acc + 32'(a[i] * b[i]);
            send_prod(32'(a[i] * b[i]), $urandom_range(0, 4));
        end
        exp_q.push_back(acc);
        recv($urandom_range(0, 4), got, ok);
        want = exp_q.pop_front();
        total++; if (!ok || got !== want || want !== 32'd100) $display("FAIL chain_sum: got %h ok %b want %h", got, ok, want); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] got, want, acc;
        bit ok;
        for (int j = 0; j < 3; j++) begin
            acc = '0;
            send_cfg(8'(j + 1));
            for (int i = 0; i <= j; i++) begin
                acc = acc + 32'(100 * j + i);
                send_prod(32'(100 * j + i), 0);
            end
            exp_q.push_back(acc);
            recv(0, got, ok);
            want = exp_q.pop_front();
            total++; if (!ok || got !== want) $display("FAIL b2b_sum_%0d: got %h ok %b want %h", j, got, ok, want); else passed++;
        end
    endtask

    initial begin
        cfg_if.val = 1'b0; cfg_if.msg = '0;
        in_if.val  = 1'b0; in_if.msg  = '0;
        out_if.rdy = 1'b0;
        test_reset();
        test_basic();
        test_zero_len();
        test_wrap();
        test_stall();
        test_reset_abort();
        test_max_len();
        test_mul_chain();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
